window_gen_3x3_stream: RTL
==========================

// Module: window_gen_3x3_stream
// PURPOSE
//   Streaming 3x3 neighbourhood generator for raster-scan pixels; feeds the median/Sobel/blur filter cores.
//   Parametrised in pixel width and maximum line length; image width is set at run time and latched per frame.
//   Handles pix_valid gaps and start-of-frame restart, and flags only fully-populated windows.
// PARAMETERS
//   DATA_W    8     bits per pixel
//   MAX_LINE  1024  max pixels per line = depth of each line buffer
//   ADDR_W    10    column counter/RAM address width; must satisfy 2**ADDR_W >= MAX_LINE
// PORTS
//   clk         in   1           rising-edge clock, sole clock domain
//   rst         in   1           asynchronous, active-high reset
//   pix_in      in   DATA_W      input pixel, raster order
//   pix_valid   in   1           pix_in accepted this cycle when high; no backpressure
//   sof         in   1           start of frame; qualified by pix_valid; marks pixel (row0,col0)
//   line_width  in   ADDR_W+1    pixels per line; sampled on accepted sof pixel and on reset release
//   win_out     out  9*DATA_W    tap k at [k*DATA_W +: DATA_W]; k=3*r+c, r0=oldest row, c0=oldest col
//   win_valid   out  1           win_out holds a complete window this cycle
//   win_col     out  ADDR_W      column of window centre (= accepted col - 1)
// BEHAVIOUR
//   - Reset: win_out=0, win_valid=0, win_col=0, col=0, row_cnt=0, width_q=MAX_LINE, tap regs=0.
//     Line-buffer contents are not cleared; row_cnt masks stale data.
//   - Nothing advances on cycles with pix_valid=0; all state holds.
//   - Accept at column x:
//       t1 = lb0[x] (row y-1), t0 = lb1[x] (row y-2)
//       lb1[x] <= t1, lb0[x] <= pix_in
//       row regs shift left: R2 <= {R2[1],R2[2],pix_in}, R1 <= {..,t1}, R0 <= {..,t0}
//   - Line buffers: write on clk; asynchronous read. Read of address x returns the pre-write value.
//   - Latency: win_out/win_valid/win_col are registered, 1 cycle after the accepting edge.
//     win_valid is a 1-cycle pulse per qualifying accept.
//   - win_valid=1 iff accepted col>=2 AND row_cnt==2. row_cnt saturates at 2.
//   - Column wrap: when col==width_q-1, next col=0 and row_cnt increments (saturating).
//     Column regs are not flushed at wrap; windows straddling lines are suppressed by the col>=2 rule.
//   - sof with pix_valid: that pixel is (row0,col0); col, row_cnt and width_q reload before use.
//     sof at any point restarts mid-frame. sof without pix_valid is ignored.
//   - width_q clamp: line_width > MAX_LINE -> MAX_LINE. line_width < 3 -> counters still run, win_valid never asserts.
//   - Reset mid-frame: immediate return to reset values. First windows appear after a new sof, or at row 2 of the
//     implicit frame starting at the first post-reset accept.
//   - Windows per frame: (W-2)*(H-2) for W,H >= 3.
// STRUCTURE
//   - Shared package img_pkg: DATA_W default, TAP_TL..TAP_BR index constants (0..8), window bus width macro.
//   - Sub-module line_buffer_ram (DATA_W x MAX_LINE, 1 write port, async read), instantiated twice (lb0, lb1).
//   - Top level contains counters, tap shift registers and output registers.
// TESTING
//   1 Reset: hold rst 3 cycles with random pix -> all outputs 0. Release; no win_valid without pix_valid.
//   2 Frame W=5,H=4, pix=16*row+col, continuous valid:
//     - first win_valid after pixel 0x22
//     - win_out taps = 00,01,02,10,11,12,20,21,22; win_col=1
//     - exactly 6 pulses; last window centre 0x23
//   3 Same frame with pix_valid low on random 40% of cycles -> identical win_out sequence; pulses only after accepts.
//   4 sof asserted at pixel (2,3) of a W=5 frame, then a new W=4 frame -> no window using old-frame rows;
//     first window = new 00..22.
//   5 line_width=2, 6 lines -> win_valid never high. line_width=MAX_LINE+5 (MAX_LINE=8) -> behaves as W=8,
//     6 pulses per row from row 2.
//   6 rst pulsed mid row 3 of W=5 frame -> outputs 0 next cycle; post-reset sof frame reproduces scenario 2 exactly.

Source files
------------

// File: rtl/img_pkg.sv
// Shared constants for the 3x3 window generator: default pixel width,
// tap indices inside the window bus and the bus width helper.
package img_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int NUM_TAPS   = 9;

  // Tap k = 3*row + col; row 0 is the oldest line, col 0 the oldest column.
  localparam int TAP_TL = 0;
  localparam int TAP_TC = 1;
  localparam int TAP_TR = 2;
  localparam int TAP_ML = 3;
  localparam int TAP_MC = 4;
  localparam int TAP_MR = 5;
  localparam int TAP_BL = 6;
  localparam int TAP_BC = 7;
  localparam int TAP_BR = 8;

  function automatic int win_bus_w(input int data_w);
    return NUM_TAPS * data_w;
  endfunction

endpackage

// File: rtl/window_gen_3x3_stream_line_buffer_ram.sv
// One line of pixel storage: single write port, combinational read that
// returns the value held before a same-cycle write.
module line_buffer_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/window_gen_3x3_stream.sv
// Streaming 3x3 neighbourhood generator: two line buffers feed three rows of
// column shift registers; only fully populated windows are flagged valid.
module window_gen_3x3_stream
  import img_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_LINE = 1024,
  parameter int ADDR_W   = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W-1:0]           pix_in,
  input  logic                        pix_valid,
  input  logic                        sof,
  input  logic [ADDR_W:0]             line_width,
  output logic [win_bus_w(DATA_W)-1:0] win_out,
  output logic                        win_valid,
  output logic [ADDR_W-1:0]           win_col
);

  localparam logic [ADDR_W:0] MAX_W = (ADDR_W+1)'(MAX_LINE);

  logic [ADDR_W-1:0] col_reg;
  logic [1:0]        row_reg;
  logic [ADDR_W:0]   width_reg;
  logic              init_reg;
  logic              win_valid_reg;
  logic [ADDR_W-1:0] win_col_reg;
  logic [DATA_W-1:0] tap_reg [3][3];

  logic              sof_acc;
  logic [ADDR_W:0]   width_in;
  logic [ADDR_W:0]   width_eff;
  logic [ADDR_W-1:0] col_eff;
  logic [1:0]        row_eff;
  logic              last_col;
  logic [DATA_W-1:0] t0, t1;
  logic [DATA_W-1:0] row_in [3];

  // An accepted sof pixel restarts counters and width in the same cycle it is used.
  assign sof_acc   = pix_valid & sof;
  assign width_in  = (line_width > MAX_W) ? MAX_W : line_width;
  assign width_eff = (sof_acc | init_reg) ? width_in : width_reg;
  assign col_eff   = sof_acc ? '0 : col_reg;
  assign row_eff   = sof_acc ? 2'd0 : row_reg;
  assign last_col  = ({1'b0, col_eff} == width_eff - 1'b1);

  line_buffer_ram #(.DATA_W(DATA_W), .DEPTH(MAX_LINE), .ADDR_W(ADDR_W)) lb0 (
    .clk(clk), .we(pix_valid), .addr(col_eff), .wdata(pix_in), .rdata(t1)
  );

  line_buffer_ram #(.DATA_W(DATA_W), .DEPTH(MAX_LINE), .ADDR_W(ADDR_W)) lb1 (
    .clk(clk), .we(pix_valid), .addr(col_eff), .wdata(t1), .rdata(t0)
  );

  assign row_in[0] = t0;
  assign row_in[1] = t1;
  assign row_in[2] = pix_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_reg       <= '0;
      row_reg       <= 2'd0;
      width_reg     <= MAX_W;
      init_reg      <= 1'b1;
      win_valid_reg <= 1'b0;
      win_col_reg   <= '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          tap_reg[r][c] <= '0;
    end else begin
      init_reg      <= 1'b0;
      win_valid_reg <= 1'b0;
      if (init_reg) width_reg <= width_in;
      if (pix_valid) begin
        width_reg     <= width_eff;
        col_reg       <= last_col ? '0 : col_eff + 1'b1;
        row_reg       <= (last_col && row_eff != 2'd2) ? row_eff + 2'd1 : row_eff;
        win_valid_reg <= (col_eff >= ADDR_W'(2)) && (row_eff == 2'd2);
        win_col_reg   <= col_eff - 1'b1;
        for (int r = 0; r < 3; r++) begin
          tap_reg[r][0] <= tap_reg[r][1];
          tap_reg[r][1] <= tap_reg[r][2];
          tap_reg[r][2] <= row_in[r];
        end
      end
    end
  end

  assign win_out[TAP_TL*DATA_W +: DATA_W] = tap_reg[0][0];
  assign win_out[TAP_TC*DATA_W +: DATA_W] = tap_reg[0][1];
  assign win_out[TAP_TR*DATA_W +: DATA_W] = tap_reg[0][2];
  assign win_out[TAP_ML*DATA_W +: DATA_W] = tap_reg[1][0];
  assign win_out[TAP_MC*DATA_W +: DATA_W] = tap_reg[1][1];
  assign win_out[TAP_MR*DATA_W +: DATA_W] = tap_reg[1][2];
  assign win_out[TAP_BL*DATA_W +: DATA_W] = tap_reg[2][0];
  assign win_out[TAP_BC*DATA_W +: DATA_W] = tap_reg[2][1];
  assign win_out[TAP_BR*DATA_W +: DATA_W] = tap_reg[2][2];
  assign win_valid = win_valid_reg;
  assign win_col   = win_col_reg;

endmodule
